// File: rtl/mux4_rr_sched_pkg.sv
// ============================================================================
// mux4_rr_sched_pkg : shared constants, state encoding and one-hot helper
// Revision 1.0
// ============================================================================
`default_nettype none

package mux4_rr_sched_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_rr_sched_mux4.sv
// ============================================================================
// mux4_rr_sched_mux4 : combinational 4:1 word multiplexer
// Revision 1.0
// ============================================================================
`default_nettype none

module mux4_rr_sched_mux4
  import mux4_rr_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic [WIDTH-1:0] din4,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din1;
    case (sel)
      2'd0:    dout = din1;
      2'd1:    dout = din2;
      2'd2:    dout = din3;
      default: dout = din4;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_sched.sv
// ============================================================================
// mux4_rr_sched : round-robin scheduler over a 4:1 mux with a one-entry
//                 valid/ready output stage
// Revision 1.0
// ============================================================================
`default_nettype none

module mux4_rr_sched
  import mux4_rr_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic [WIDTH-1:0] din4,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [1:0]       sel
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]   dout_q, dout_d;

  logic               w_can_accept;
  logic               w_found;
  logic [SEL_W-1:0]   w_winner;
  logic [SEL_W-1:0]   w_cand;
  logic               w_accept;
  logic [WIDTH-1:0]   w_mux_out;

  assign w_can_accept = (state_q == ST_EMPTY) | dout_ready;

  // Search ptr, ptr+1, ptr+2, ptr+3; the 2-bit sum wraps naturally mod 4.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = ptr_q + SEL_W'(k);
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_accept = ~rst & w_can_accept & w_found;
  assign gnt      = w_accept ? onehot(w_winner) : '0;

  mux4_rr_sched_mux4 #(
    .WIDTH (WIDTH)
  ) u_mux4 (
    .din1 (din1),
    .din2 (din2),
    .din3 (din3),
    .din4 (din4),
    .sel  (w_winner),
    .dout (w_mux_out)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    if (w_accept) begin
      state_d = ST_FULL;
      dout_d  = w_mux_out;
      sel_d   = w_winner;
      ptr_d   = w_winner + 2'd1;
    end else if (state_q == ST_FULL && dout_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      sel_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
    end
  end

  assign dout       = dout_q;
  assign sel        = sel_q;
  assign dout_valid = (state_q == ST_FULL);

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_sched.sv
// ============================================================================
// tb_mux4_rr_sched : directed self-checking bench for mux4_rr_sched
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mux4_rr_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] din1, din2, din3, din4;
  logic [3:0] gnt;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [1:0] sel;

  int n_tests;
  int n_fail;

  mux4_rr_sched #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .din4       (din4),
    .gnt        (gnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sel        (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs changed afterwards settle before checks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] s,
                         input logic v);
    check({tag, ".dout"},  {24'd0, dout}, {24'd0, d});
    check({tag, ".sel"},   {30'd0, sel},  {30'd0, s});
    check({tag, ".valid"}, {31'd0, dout_valid}, {31'd0, v});
  endtask

  task automatic chk_gnt(input string tag, input logic [3:0] g);
    #1;
    check({tag, ".gnt"}, {28'd0, gnt}, {28'd0, g});
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req        = 4'hF;
    dout_ready = 1'b1;
    din1 = 8'h11; din2 = 8'h22; din3 = 8'h33; din4 = 8'h44;

    // 1) reset holds everything idle even with all requests high
    step();
    chk_gnt("rst0", 4'b0000);
    chk_out("rst0", 8'h00, 2'd0, 1'b0);
    step();
    chk_gnt("rst1", 4'b0000);
    chk_out("rst1", 8'h00, 2'd0, 1'b0);

    // 2) single requester 3
    rst = 1'b0; req = 4'b0100; din3 = 8'hA5;
    chk_gnt("t2", 4'b0100);
    step();
    chk_out("t2", 8'hA5, 2'd2, 1'b1);
    req = 4'hF;
    chk_gnt("t2.ptr3", 4'b1000);

    // 3) full rotation with wrap, starting from ptr=0
    rst = 1'b1; din3 = 8'h33;
    step();
    rst = 1'b0;
    chk_gnt("t3.first", 4'b0001);
    step(); chk_out("t3.w0", 8'h11, 2'd0, 1'b1);
    step(); chk_out("t3.w1", 8'h22, 2'd1, 1'b1);
    step(); chk_out("t3.w2", 8'h33, 2'd2, 1'b1);
    step(); chk_out("t3.w3", 8'h44, 2'd3, 1'b1);
    step(); chk_out("t3.w4", 8'h11, 2'd0, 1'b1);

    // 4) stall while holding 0x22
    step(); chk_out("t4.load", 8'h22, 2'd1, 1'b1);
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_gnt("t4.stall", 4'b0000);
      step();
      chk_out("t4.hold", 8'h22, 2'd1, 1'b1);
    end
    dout_ready = 1'b1;
    chk_gnt("t4.resume", 4'b0100);
    step(); chk_out("t4.next", 8'h33, 2'd2, 1'b1);

    // 5) ptr=1 with req 1001 -> requester 4 first, then requester 1
    rst = 1'b1;
    step();
    rst = 1'b0; req = 4'b0001;
    step(); chk_out("t5.seed", 8'h11, 2'd0, 1'b1);
    req = 4'b1001;
    chk_gnt("t5.a", 4'b1000);
    step(); chk_out("t5.a", 8'h44, 2'd3, 1'b1);
    chk_gnt("t5.b", 4'b0001);
    step(); chk_out("t5.b", 8'h11, 2'd0, 1'b1);
    req = 4'b0000;
    chk_gnt("t5.idle", 4'b0000);
    step(); chk_out("t5.drain", 8'h11, 2'd0, 1'b0);
    step(); chk_out("t5.empty", 8'h11, 2'd0, 1'b0);
    // idle cycles must not have moved ptr (still 1 after winner 0)
    req = 4'b1010;
    chk_gnt("t5.ptr", 4'b0010);
    step(); chk_out("t5.ptrw", 8'h22, 2'd1, 1'b1);

    // 6) reset while FULL with 0x44; ptr left at 1 so reset must clear it
    req = 4'b0000; din1 = 8'h44;
    step();
    req = 4'b0001;
    step(); chk_out("t6.full", 8'h44, 2'd0, 1'b1);
    rst = 1'b1; req = 4'hF;
    chk_gnt("t6.rst", 4'b0000);
    step(); chk_out("t6.rst", 8'h00, 2'd0, 1'b0);
    rst = 1'b0; req = 4'b1001; din1 = 8'h11;
    chk_gnt("t6.after", 4'b0001);
    step(); chk_out("t6.after", 8'h11, 2'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
